// File: rtl/shadow_seq_pkg.sv
// Shared types and default parameters for the shadow configuration sequencer.
package shadow_seq_pkg;

    localparam int unsigned DEF_REG_WIDTH      = 32;
    localparam int unsigned DEF_NUM_REGS       = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 256;
    localparam int unsigned DEF_RETRY_MAX      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_APPLY,
        ST_WAIT,
        ST_VERIFY,
        ST_ROLLBACK,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_VERIFY  = 2'd2,
        ERR_EMPTY   = 2'd3
    } err_code_t;

endpackage

// File: rtl/shadow_seq_timer.sv
// Saturating cycle counter with synchronous clear and an expiry flag at TIMEOUT_CYCLES-1.
module shadow_seq_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic cfg_clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Holds at TIMEOUT_CYCLES instead of wrapping
    always_ff @(posedge cfg_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired_c = (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/shadow_cfg_seq.sv
// Host-to-shadow register update sequencer: write, apply, wait, optional verify/retry, rollback.
// Define SHADOW_SEQ_VERIFY_EN to build the readback VERIFY state and retry logic.
module shadow_cfg_seq
    import shadow_seq_pkg::*;
#(
    parameter int unsigned REG_WIDTH      = DEF_REG_WIDTH,
    parameter int unsigned NUM_REGS       = DEF_NUM_REGS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned RETRY_MAX      = DEF_RETRY_MAX
) (
    input  logic                          cfg_clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [NUM_REGS-1:0]           req_mask,
    input  logic [NUM_REGS*REG_WIDTH-1:0] req_data,
    output logic [NUM_REGS-1:0]           wr_en,
    output logic [NUM_REGS*REG_WIDTH-1:0] wr_data,
    output logic                          shadow_apply,
    output logic                          shadow_rollback,
    input  logic                          shadow_valid,
    input  logic                          shadow_busy,
    input  logic [NUM_REGS*REG_WIDTH-1:0] rd_data,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    err_code
);

    localparam int unsigned DATA_W = NUM_REGS * REG_WIDTH;

    state_t                r_state, w_state_nxt;
    logic [NUM_REGS-1:0]   r_mask, w_mask_nxt;
    logic [DATA_W-1:0]     r_data, w_data_nxt;
    logic                  r_busy_seen, w_busy_seen_nxt;
    err_code_t             r_err_code, w_err_code_nxt;
    logic                  w_apply_nxt;
    logic                  w_timer_clr;
    logic                  w_timer_en;
    logic                  w_expired_c;

    logic                  r_req_ready;
    logic [NUM_REGS-1:0]   r_wr_en;
    logic [DATA_W-1:0]     r_wr_data;
    logic                  r_apply;
    logic                  r_rollback;
    logic                  r_done;
    logic                  r_err;

`ifdef SHADOW_SEQ_VERIFY_EN
    localparam int unsigned RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    logic [RETRY_W-1:0] r_retry_cnt, w_retry_nxt;
    logic [DATA_W-1:0]  w_bit_mask;
    logic               w_verify_ok;

    // Only masked registers take part in the readback compare
    always_comb begin
        w_bit_mask = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            w_bit_mask[i*REG_WIDTH +: REG_WIDTH] = {REG_WIDTH{r_mask[i]}};
        end
    end

    assign w_verify_ok = (((rd_data ^ r_data) & w_bit_mask) == '0);
`else
    logic w_unused_rd;
    assign w_unused_rd = (^rd_data) ^ (RETRY_MAX != 0);
`endif

    shadow_seq_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .cfg_clk     (cfg_clk),
        .rst_n       (rst_n),
        .i_clr       (w_timer_clr),
        .i_en        (w_timer_en),
        .o_expired_c (w_expired_c)
    );

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_data_nxt      = r_data;
        w_busy_seen_nxt = r_busy_seen;
        w_err_code_nxt  = r_err_code;
        w_apply_nxt     = 1'b0;
`ifdef SHADOW_SEQ_VERIFY_EN
        w_retry_nxt     = r_retry_cnt;
`endif

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_mask_nxt     = req_mask;
                    w_data_nxt     = req_data;
                    w_err_code_nxt = ERR_NONE;
`ifdef SHADOW_SEQ_VERIFY_EN
                    w_retry_nxt    = '0;
`endif
                    if (req_mask == '0) begin
                        w_state_nxt    = ST_FINISH;
                        w_err_code_nxt = ERR_EMPTY;
                    end else begin
                        w_state_nxt    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                if (shadow_valid && !shadow_busy) begin
                    w_apply_nxt     = 1'b1;
                    w_busy_seen_nxt = 1'b0;
                    w_state_nxt     = ST_WAIT;
                end else if (w_expired_c) begin
                    w_state_nxt    = ST_FINISH;
                    w_err_code_nxt = ERR_TIMEOUT;
                end
            end
            ST_WAIT: begin
                if (shadow_busy) begin
                    w_busy_seen_nxt = 1'b1;
                end
                if (!shadow_busy && r_busy_seen) begin
`ifdef SHADOW_SEQ_VERIFY_EN
                    w_state_nxt    = ST_VERIFY;
`else
                    w_state_nxt    = ST_FINISH;
                    w_err_code_nxt = ERR_NONE;
`endif
                end else if (w_expired_c) begin
                    if (shadow_busy) begin
                        w_state_nxt    = ST_ROLLBACK;
                    end else begin
                        w_state_nxt    = ST_FINISH;
                        w_err_code_nxt = ERR_TIMEOUT;
                    end
                end
            end
`ifdef SHADOW_SEQ_VERIFY_EN
            ST_VERIFY: begin
                if (w_verify_ok) begin
                    w_state_nxt    = ST_FINISH;
                    w_err_code_nxt = ERR_NONE;
                end else if (r_retry_cnt < RETRY_W'(RETRY_MAX)) begin
                    w_retry_nxt    = r_retry_cnt + RETRY_W'(1);
                    w_state_nxt    = ST_WRITE;
                end else begin
                    w_state_nxt    = ST_FINISH;
                    w_err_code_nxt = ERR_VERIFY;
                end
            end
`endif
            ST_ROLLBACK: begin
                w_state_nxt    = ST_FINISH;
                w_err_code_nxt = ERR_TIMEOUT;
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_timer_en  = (r_state == ST_APPLY) || (r_state == ST_WAIT);
        w_timer_clr = (w_state_nxt != r_state) &&
                      ((w_state_nxt == ST_APPLY) || (w_state_nxt == ST_WAIT));
    end

    // State and request latches
    always_ff @(posedge cfg_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_data      <= '0;
            r_busy_seen <= 1'b0;
            r_err_code  <= ERR_NONE;
`ifdef SHADOW_SEQ_VERIFY_EN
            r_retry_cnt <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_data      <= w_data_nxt;
            r_busy_seen <= w_busy_seen_nxt;
            r_err_code  <= w_err_code_nxt;
`ifdef SHADOW_SEQ_VERIFY_EN
            r_retry_cnt <= w_retry_nxt;
`endif
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to
    always_ff @(posedge cfg_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b1;
            r_wr_en     <= '0;
            r_wr_data   <= '0;
            r_apply     <= 1'b0;
            r_rollback  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_wr_en     <= (w_state_nxt == ST_WRITE) ? w_mask_nxt : '0;
            r_wr_data   <= (w_state_nxt == ST_WRITE) ? w_data_nxt : '0;
            r_apply     <= w_apply_nxt;
            r_rollback  <= (w_state_nxt == ST_ROLLBACK);
            r_done      <= (w_state_nxt == ST_FINISH) && (w_err_code_nxt == ERR_NONE);
            r_err       <= (w_state_nxt == ST_FINISH) && (w_err_code_nxt != ERR_NONE);
        end
    end

    assign req_ready       = r_req_ready;
    assign wr_en           = r_wr_en;
    assign wr_data         = r_wr_data;
    assign shadow_apply    = r_apply;
    assign shadow_rollback = r_rollback;
    assign done            = r_done;
    assign err             = r_err;
    assign err_code        = r_err_code;

endmodule

// File: tb/tb_shadow_cfg_seq.sv
// Scoreboard bench for shadow_cfg_seq with a behavioural shadow-block responder.
module tb_shadow_cfg_seq;

    localparam int RW = 8;
    localparam int NR = 4;
    localparam int TO = 16;
    localparam int RM = 2;
    localparam int DW = RW * NR;

`ifdef SHADOW_SEQ_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    localparam int M_OK      = 0;
    localparam int M_NOVALID = 1;
    localparam int M_NOBUSY  = 2;
    localparam int M_HANG    = 3;
    localparam int M_BADRB   = 4;

    logic          cfg_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [NR-1:0] req_mask = '0;
    logic [DW-1:0] req_data = '0;
    logic [NR-1:0] wr_en;
    logic [DW-1:0] wr_data;
    logic          shadow_apply, shadow_rollback;
    logic          shadow_valid = 1'b1;
    logic          shadow_busy  = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          done, err;
    logic [1:0]    err_code;

    shadow_cfg_seq #(
        .REG_WIDTH(RW), .NUM_REGS(NR), .TIMEOUT_CYCLES(TO), .RETRY_MAX(RM)
    ) dut (
        .cfg_clk(cfg_clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mask(req_mask), .req_data(req_data),
        .wr_en(wr_en), .wr_data(wr_data),
        .shadow_apply(shadow_apply), .shadow_rollback(shadow_rollback),
        .shadow_valid(shadow_valid), .shadow_busy(shadow_busy),
        .rd_data(rd_data),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 cfg_clk = ~cfg_clk;

    typedef struct {
        bit            is_err;
        logic [1:0]    code;
        int            writes;
        int            applies;
        int            rollbacks;
        logic [NR-1:0] mask;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_wr = 0, n_ap = 0, n_rb = 0, ap_cyc = 0;

    // Responder configuration for the current transaction
    bit m_valid_ok = 1'b1;
    bit m_hang     = 1'b0;
    bit m_corrupt  = 1'b0;
    int m_busy_len = 3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [DW-1:0] bmask(input logic [NR-1:0] m);
        logic [DW-1:0] b;
        b = '0;
        for (int i = 0; i < NR; i++) b[i*RW +: RW] = {RW{m[i]}};
        return b;
    endfunction

    // Expected outcome of one request, from the behaviour of the shadow block it meets
    function automatic exp_t model(input logic [NR-1:0] mask, input logic [DW-1:0] data, input int mode);
        exp_t e;
        e.mask = mask; e.data = data; e.rollbacks = 0;
        e.is_err = 1'b0; e.code = 2'd0; e.writes = 1; e.applies = 1;
        if (mask == '0) begin
            e.is_err = 1'b1; e.code = 2'd3; e.writes = 0; e.applies = 0;
        end else if (mode == M_NOVALID) begin
            e.is_err = 1'b1; e.code = 2'd1; e.applies = 0;
        end else if (mode == M_NOBUSY) begin
            e.is_err = 1'b1; e.code = 2'd1;
        end else if (mode == M_HANG) begin
            e.is_err = 1'b1; e.code = 2'd1; e.rollbacks = 1;
        end else if (mode == M_BADRB && VERIFY_ON && mask[0]) begin
            e.is_err = 1'b1; e.code = 2'd2; e.writes = RM + 1; e.applies = RM + 1;
        end
        return e;
    endfunction

    // Shadow block: stages writes, commits them to the active copy after its busy period
    initial begin
        logic [RW-1:0] staged [NR];
        logic [RW-1:0] active [NR];
        int busy_cnt;
        busy_cnt = 0;
        for (int i = 0; i < NR; i++) begin
            active[i] = RW'($urandom);
            staged[i] = active[i];
        end
        forever begin
            @(negedge cfg_clk);
            if (!rst_n) begin
                busy_cnt = 0;
                shadow_busy = 1'b0;
                for (int i = 0; i < NR; i++) staged[i] = active[i];
            end else begin
                for (int i = 0; i < NR; i++)
                    if (wr_en[i]) staged[i] = wr_data[i*RW +: RW];
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        for (int i = 0; i < NR; i++) active[i] = staged[i];
                        if (m_corrupt) active[0] = active[0] ^ 8'h5A;
                        shadow_busy = 1'b0;
                    end
                end
                if (shadow_rollback) begin
                    busy_cnt = 0;
                    shadow_busy = 1'b0;
                    for (int i = 0; i < NR; i++) staged[i] = active[i];
                end
                if (shadow_apply) begin
                    if (m_hang) begin
                        shadow_busy = 1'b1;
                    end else if (m_busy_len == 0) begin
                        for (int i = 0; i < NR; i++) active[i] = staged[i];
                    end else begin
                        busy_cnt = m_busy_len;
                        shadow_busy = 1'b1;
                    end
                end
            end
            shadow_valid = m_valid_ok;
            for (int i = 0; i < NR; i++) rd_data[i*RW +: RW] = active[i];
        end
    end

    // Monitor: accumulates pulses per transaction and scores each done/err against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge cfg_clk);
            cyc++;
            if (rst_n) begin
                chk("apply_rollback_exclusive", 64'(shadow_apply & shadow_rollback), 64'd0);
                if (wr_en != '0) begin
                    n_wr++;
                    if (q.size() > 0) begin
                        chk("wr_en", 64'(wr_en), 64'(q[0].mask));
                        chk("wr_data", 64'(wr_data & bmask(q[0].mask)), 64'(q[0].data & bmask(q[0].mask)));
                    end else begin
                        flag("write_without_request", 64'(wr_en), 64'd0);
                    end
                end
                if (shadow_apply) begin
                    n_ap++;
                    ap_cyc = cyc;
                end
                if (shadow_rollback) begin
                    n_rb++;
                    chk("rollback_delay", 64'(cyc - ap_cyc), 64'(TO));
                end
                if (done || err) begin
                    if (q.size() == 0) begin
                        flag("unexpected_completion", 64'({done, err}), 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("done", 64'(done), 64'(!e.is_err));
                        chk("err", 64'(err), 64'(e.is_err));
                        chk("err_code", 64'(err_code), 64'(e.code));
                        chk("write_rounds", 64'(n_wr), 64'(e.writes));
                        chk("apply_pulses", 64'(n_ap), 64'(e.applies));
                        chk("rollback_pulses", 64'(n_rb), 64'(e.rollbacks));
                    end
                    n_wr = 0; n_ap = 0; n_rb = 0;
                end
            end
        end
    end

    task automatic issue(input logic [NR-1:0] mask, input logic [DW-1:0] data,
                         input int mode, input int blen, output logic [1:0] code);
        int n;
        exp_t e;
        n = 0;
        while (!req_ready && n < 300) begin
            @(posedge cfg_clk); #1;
            n++;
        end
        if (!req_ready) flag("ready_timeout", 64'(req_ready), 64'd1);
        m_valid_ok = (mode != M_NOVALID);
        m_hang     = (mode == M_HANG);
        m_corrupt  = (mode == M_BADRB);
        m_busy_len = (mode == M_NOBUSY) ? 0 : blen;
        e = model(mask, data, mode);
        code = e.code;
        q.push_back(e);
        req_valid = 1'b1;
        req_mask  = mask;
        req_data  = data;
        @(posedge cfg_clk); #1;
        req_valid = 1'b0;
        if (mask == '0) begin
            chk("ready_low_after_empty", 64'(req_ready), 64'd0);
            @(posedge cfg_clk); #1;
            chk("ready_back_after_empty", 64'(req_ready), 64'd1);
        end else begin
            // A request raised while busy must be ignored
            req_valid = 1'b1;
            req_mask  = NR'($urandom);
            req_data  = DW'($urandom);
            @(posedge cfg_clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input logic [1:0] code);
        int n;
        n = 0;
        while (q.size() > 0 && n < 400) begin
            @(posedge cfg_clk); #1;
            n++;
        end
        if (q.size() > 0) begin
            flag("completion_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end else begin
            @(posedge cfg_clk); #1;
            chk("err_code_held", 64'(err_code), 64'(code));
            chk("ready_after_finish", 64'(req_ready), 64'd1);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        chk({tag, "_apply"}, 64'(shadow_apply), 64'd0);
        chk({tag, "_rollback"}, 64'(shadow_rollback), 64'd0);
        chk({tag, "_done_err"}, 64'({done, err}), 64'd0);
        chk({tag, "_err_code"}, 64'(err_code), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] code;
        int n, mode, r;
        repeat (3) @(posedge cfg_clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge cfg_clk); #1;

        // Two masked registers, three busy cycles
        issue(4'b0101, 32'h000B000A, M_OK, 3, code);
        wait_done(code);
        // Empty mask
        issue(4'b0000, DW'($urandom), M_OK, 3, code);
        wait_done(code);
        // Shadow stays busy: rollback after the wait timeout
        issue(4'b1111, DW'($urandom), M_HANG, 0, code);
        wait_done(code);
        // Readback disagrees in reg0
        issue(4'b0001, DW'($urandom), M_BADRB, 2, code);
        wait_done(code);

        // Reset while waiting on a busy shadow block
        issue(4'b0110, DW'($urandom), M_HANG, 0, code);
        n = 0;
        while (n_ap == 0 && n < 100) begin
            @(posedge cfg_clk); #1;
            n++;
        end
        if (n_ap == 0) flag("apply_before_reset", 64'(n_ap), 64'd1);
        repeat (3) @(posedge cfg_clk);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk_idle_outputs("async_reset");
        @(posedge cfg_clk); #1;
        chk_idle_outputs("reset_next_cycle");
        rst_n = 1'b1;
        n_wr = 0; n_ap = 0; n_rb = 0;
        m_hang = 1'b0;
        repeat (20) @(posedge cfg_clk);
        #1;
        chk("idle_after_abort", 64'(req_ready), 64'd1);

        // Randomised traffic
        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)       mode = M_OK;
            else if (r == 5) mode = M_NOVALID;
            else if (r == 6) mode = M_NOBUSY;
            else if (r == 7) mode = M_HANG;
            else             mode = M_BADRB;
            issue(NR'($urandom_range(0, 15)), DW'($urandom), mode,
                  int'($urandom_range(1, 5)), code);
            wait_done(code);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shadow_cfg_seq.md
SHADOW_CFG_SEQ -- requirements
Module: shadow_cfg_seq

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, width of one config register.
REQ-002 SHALL have parameter NUM_REGS, default 4, number of shadowed registers.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum cfg_clk cycles allowed in APPLY or WAIT.
REQ-004 SHALL have parameter RETRY_MAX, default 2, number of verify-mismatch retries before error.
REQ-005 SHALL have port cfg_clk, input, 1, sole clock; reset rst_n, asynchronous, active-low; clock cfg_clk.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, host update request.
REQ-008 SHALL have port req_ready, output, 1, sequencer idle and accepting requests.
REQ-009 SHALL have port req_mask, input, NUM_REGS, which registers the request updates.
REQ-010 SHALL have port req_data, input, NUM_REGS*REG_WIDTH, new values; reg i occupies bits [i*REG_WIDTH +: REG_WIDTH].
REQ-011 SHALL have port wr_en, output, NUM_REGS, shadow write enables.
REQ-012 SHALL have port wr_data, output, NUM_REGS*REG_WIDTH, shadow write data, same packing as req_data.
REQ-013 SHALL have port shadow_apply and shadow_rollback, outputs, 1 each, single-cycle pulses to the shadow block.
REQ-014 SHALL have port shadow_valid and shadow_busy, inputs, 1 each, shadow block status.
REQ-015 SHALL have port rd_data, input, NUM_REGS*REG_WIDTH, ACTIVE readback, same packing.
REQ-016 SHALL have port done, output, 1, one-cycle pulse on successful update.
REQ-017 SHALL have port err, output, 1, one-cycle pulse on failed update.
REQ-018 SHALL have port err_code, output, 2, 0 none, 1 timeout, 2 verify fail, 3 empty mask; held until next request is accepted.

Function
REQ-019 SHALL implement the FSM IDLE, WRITE, APPLY, WAIT, VERIFY, ROLLBACK, FINISH.
REQ-020 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0, and req_valid SHALL be ignored.
REQ-021 On req_valid&&req_ready, the block SHALL latch req_mask and req_data, clear retry_cnt and err_code, and go to WRITE; if the mask is 0 it SHALL instead go to FINISH with err_code=3.
REQ-022 WRITE SHALL last exactly one cycle, driving wr_en=latched mask and wr_data=latched data, then go to APPLY.
REQ-023 In APPLY, shadow_apply SHALL pulse for exactly one cycle, in the first cycle with shadow_valid=1 and shadow_busy=0, then the FSM SHALL go to WAIT.
REQ-024 In WAIT, the FSM SHALL record that shadow_busy was seen high, and SHALL leave when shadow_busy=0 after having been seen high (to VERIFY).
REQ-025 The timeout counter SHALL clear on entry to APPLY and WAIT and increment each cycle in those states.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1 in APPLY, the FSM SHALL go to FINISH with err_code=1; in WAIT with shadow_busy=1, it SHALL go to ROLLBACK; in WAIT with shadow_busy=0, it SHALL go to FINISH with err_code=1.
REQ-027 In VERIFY (one cycle), rd_data SHALL be compared to the latched data for masked registers only; on match go to FINISH with err_code=0.
REQ-028 On a VERIFY mismatch with retry_cnt<RETRY_MAX, retry_cnt SHALL increment and the FSM SHALL go to WRITE; otherwise it SHALL go to FINISH with err_code=2.
REQ-029 ROLLBACK SHALL pulse shadow_rollback for one cycle, then go to FINISH with err_code=1.
REQ-030 FINISH SHALL pulse done (err_code=0) or err (err_code!=0) for one cycle, then return to IDLE.
REQ-031 The counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits and saturate, never wrap.
REQ-032 shadow_apply and shadow_rollback SHALL never be asserted in the same cycle.

Reset
REQ-033 On rst_n=0, the FSM SHALL enter IDLE with req_ready=1 and wr_en, wr_data, shadow_apply, shadow_rollback, done, err, err_code, counters and latches all 0.
REQ-034 A reset mid-operation SHALL abort with no apply, rollback, done or err pulse emitted.

Configuration
REQ-035 With macro SHADOW_SEQ_VERIFY_EN defined, the VERIFY state and retry logic SHALL be present.
REQ-036 Without SHADOW_SEQ_VERIFY_EN, WAIT SHALL exit directly to FINISH with err_code=0, rd_data SHALL be unused, and err_code=2 SHALL never occur.

Structure
REQ-037 A package shadow_seq_pkg SHALL hold the state enum, the err_code enum, and default parameter constants.
REQ-038 One sub-module, shadow_seq_timer (loadable clear, saturating counter, expiry flag), SHALL be instantiated.

Verification
REQ-039 Mask 4'b0101 with data {0,0xB,0,0xA}, responsive model, busy high 3 cycles -> wr_en=0101 for one cycle, one apply pulse, done pulse, err_code=0.
REQ-040 Model holds shadow_busy=1 forever, TIMEOUT_CYCLES=16 -> shadow_rollback pulse 16 cycles after apply, then err pulse with err_code=1.
REQ-041 Model readback differs in reg0 (verify enabled, RETRY_MAX=2) -> exactly 3 WRITE/apply rounds, then err_code=2.
REQ-042 req_valid with mask 0 -> no wr_en or apply, err pulse, err_code=3, req_ready returns high 2 cycles after acceptance.
REQ-043 Assert rst_n=0 during WAIT -> all outputs 0 and req_ready=1 the next cycle, with no done/err pulse.
